dir_cmd_scheduler: RTL

DIR_CMD_SCHEDULER -- requirements
Module: dir_cmd_scheduler

---
 rtl/dir_cmd_scheduler.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/dir_cmd_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : dir_cmd_scheduler
//  Description : Queues direction key presses from a scancode decoder and
//                commits them one per game step. Duplicate presses (and,
//                optionally, reversals) are dropped. The queue is circular.
//                Optional feature macro: DIRQ_REVERSE_FILTER_EN. When it is
//                defined, a key opposite to the reference direction is
//                rejected.
//  Revision    : 1.0  initial release
// ============================================================================
module dir_cmd_scheduler #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     up_make,
    input  logic                     down_make,
    input  logic                     left_make,
    input  logic                     right_make,
    input  logic                     tick,
    input  logic                     flush,
    output logic [1:0]               heading,
    output logic                     moving,
    output logic                     turn,
    output logic                     drop,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    localparam logic [0:0] ST_ARMED = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [1:0]    mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    heading_q, heading_d;
    logic [0:0]    state_q, state_d;
    logic          turn_q, turn_d;
    logic          drop_q, drop_d;

    logic          w_cand_vld;
    logic [1:0]    w_cand;
    logic [1:0]    w_ref;
    logic          w_dup;
    logic          w_opp;
    logic          w_reject;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic [1:0]    w_head;

    // Candidate selection, reference direction and accept/reject decision
    always_comb begin
        w_cand_vld = up_make | down_make | left_make | right_make;
        if (up_make)
            w_cand = DIR_UP;
        else if (down_make)
            w_cand = DIR_DOWN;
        else if (left_make)
            w_cand = DIR_LEFT;
        else
            w_cand = DIR_RIGHT;

        // Compare against what will be committed last: the tail entry when
        // the queue holds anything, otherwise the current heading.
        w_ref  = (count_q != '0) ? mem_q[wptr_q - PW'(1)] : heading_q;
        w_dup  = (w_cand == w_ref);
        // Opposite pairs differ only in bit 0 (UP/DOWN, LEFT/RIGHT).
        w_opp  = (w_cand == (w_ref ^ 2'b01));
`ifdef DIRQ_REVERSE_FILTER_EN
        w_reject = w_dup | w_opp;
`else
        w_reject = w_dup;
`endif
        w_full = (count_q == CW'(DEPTH));
        w_head = mem_q[rptr_q];
        w_pop  = (state_q == ST_RUN) && tick && (count_q != '0);
        // The first key after arming bypasses the direction filter; a full
        // queue still accepts when a pop frees a slot in the same cycle.
        w_push = w_cand_vld && ((state_q == ST_ARMED) || !w_reject)
                            && (!w_full || w_pop);
    end

    // Next-state computation; flush overrides keys and tick
    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        heading_d = heading_q;
        state_d   = state_q;
        turn_d    = 1'b0;
        drop_d    = 1'b0;
        if (flush) begin
            wptr_d    = '0;
            rptr_d    = '0;
            count_d   = '0;
            heading_d = DIR_RIGHT;
            state_d   = ST_ARMED;
        end else begin
            if (w_push)
                wptr_d = wptr_q + PW'(1);
            if (w_pop) begin
                rptr_d    = rptr_q + PW'(1);
                heading_d = w_head;
                turn_d    = (w_head != heading_q);
            end
            count_d = count_q + CW'(w_push) - CW'(w_pop);
            drop_d  = w_cand_vld && !w_push;
            if ((state_q == ST_ARMED) && w_push)
                state_d = ST_RUN;
        end
    end

    // Control state registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            heading_q <= DIR_RIGHT;
            state_q   <= ST_ARMED;
            turn_q    <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            heading_q <= heading_d;
            state_q   <= state_d;
            turn_q    <= turn_d;
            drop_q    <= drop_d;
        end
    end

    // Queue storage; contents are don't-care until written, pointers gate use
    always_ff @(posedge clk) begin
        if (!flush && w_push)
            mem_q[wptr_q] <= w_cand;
    end

    assign heading = heading_q;
    assign moving  = (state_q == ST_RUN);
    assign turn    = turn_q;
    assign drop    = drop_q;
    assign q_count = count_q;

endmodule
`default_nettype wire
